// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial subtractor. It computes A + ~B + carry_in one bit per clock,
//   starting at the LSB, and produces the difference word plus ARM-style
//   CNZV flags (C = NOT borrow). Rn/Op2 can be swapped on entry, which gives
//   SUB/SBC (in_Reverse=0) and RSB/RSC (in_Reverse=1).
//
// Handshake: in_Start is sampled on a rising edge only while out_Busy is low
//   (IDLE or DONE). An accepted start raises out_Busy for WIDTH cycles. Then
//   out_Done pulses for one cycle, and out_Y/out_CNZV are valid from that
//   cycle until the next accepted start completes. A start during RUN is
//   dropped.
//
// Ports:
//   in_Clk      clock, rising edge
//   in_Rst_N    synchronous active-low reset
//   in_Start    operation request
//   in_Rn       first operand  [WIDTH]
//   in_Op2      second operand [WIDTH]
//   in_Carry    carry in (1 for SUB/RSB, C flag for SBC/RSC)
//   in_Reverse  0: Rn - Op2, 1: Op2 - Rn
//   out_Busy    high while bits are being processed
//   out_Done    one-cycle pulse when the result is valid
//   out_Y       difference [WIDTH]
//   out_CNZV    {C,N,Z,V}
//
// Parameters: WIDTH >= 2, and 2**CNT_W must exceed WIDTH.
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             in_Clk,
  input  logic             in_Rst_N,
  input  logic             in_Start,
  input  logic [WIDTH-1:0] in_Rn,
  input  logic [WIDTH-1:0] in_Op2,
  input  logic             in_Carry,
  input  logic             in_Reverse,
  output logic             out_Busy,
  output logic             out_Done,
  output logic [WIDTH-1:0] out_Y,
  output logic [3:0]       out_CNZV
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;     // shifts right; a_q[0] is the current bit
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d; // partial result, filled from the MSB end
  logic             c_q, c_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [3:0]       cnzv_q, cnzv_d;

  logic             sum_bit;
  logic             carry_out;
  logic [1:0]       bit_sum;
  logic [WIDTH-1:0] y_final;
  logic             last_bit;
  logic             accept;

  // One full-adder step on the current bit pair.
  assign bit_sum   = {1'b0, a_q[0]} + {1'b0, ~b_q[0]} + {1'b0, c_q};
  assign sum_bit   = bit_sum[0];
  assign carry_out = bit_sum[1];

  // A new bit enters at the top. After WIDTH shifts, bit 0 holds the first
  // bit that was processed, so no separate indexing by the counter is needed.
  assign y_final  = {sum_bit, acc_q[WIDTH-1:1]};
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  assign accept   = in_Start && (state_q != S_RUN);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    c_d     = c_q;
    y_d     = y_q;
    cnzv_d  = cnzv_q;

    case (state_q)
      S_RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = carry_out;
        acc_d = y_final;
        cnt_d = cnt_q + 1'b1;
        if (last_bit) begin
          state_d = S_DONE;
          y_d     = y_final;
          // On the last bit, a_q[0] and b_q[0] are the operand MSBs.
          cnzv_d  = {carry_out,
                     sum_bit,
                     (y_final == '0),
                     (a_q[0] != b_q[0]) && (sum_bit != a_q[0])};
        end
      end
      default: begin // IDLE and DONE behave the same for a new request
        if (accept) begin
          state_d = S_RUN;
          cnt_d   = '0;
          a_d     = in_Reverse ? in_Op2 : in_Rn;
          b_d     = in_Reverse ? in_Rn  : in_Op2;
          c_d     = in_Carry;
          acc_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge in_Clk) begin
    if (!in_Rst_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      c_q     <= 1'b0;
      y_q     <= '0;
      cnzv_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      y_q     <= y_d;
      cnzv_q  <= cnzv_d;
    end
  end

  assign out_Busy = (state_q == S_RUN);
  assign out_Done = (state_q == S_DONE);
  assign out_Y    = y_q;
  assign out_CNZV = cnzv_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//   Directed vectors with hand-computed results. The driver pushes {Y,CNZV}
//   into exp_q when it issues an operation. The monitor pops and compares on
//   every out_Done pulse. The driver also checks latency, busy length, result
//   hold, ignored starts and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] rn;
  logic [W-1:0] op2;
  logic         carry;
  logic         rev;
  logic         busy;
  logic         done;
  logic [W-1:0] y;
  logic [3:0]   cnzv;

  logic [W+3:0] exp_q[$];
  int           n_cmp;
  int           n_fail;
  logic         prev_done;

  serial_subtractor #(.WIDTH(W), .CNT_W(6)) dut (
    .in_Clk     (clk),
    .in_Rst_N   (rst_n),
    .in_Start   (start),
    .in_Rn      (rn),
    .in_Op2     (op2),
    .in_Carry   (carry),
    .in_Reverse (rev),
    .out_Busy   (busy),
    .out_Done   (done),
    .out_Y      (y),
    .out_CNZV   (cnzv)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- comparison helper ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial prev_done = 1'b0;
  always @(negedge clk) begin
    if (done) begin
      chk("done_one_cycle", 64'(prev_done), 64'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        chk("result_y_cnzv", 64'({y, cnzv}), 64'(exp_q.pop_front()));
      end
    end
    prev_done = done;
  end

  // ---------------- driver ----------------
  // ign_at: busy cycle (1-based) at which a stray start is pulsed (0 = none)
  // rst_at: busy cycle at which reset is pulsed (0 = none; no result expected)
  task automatic run_op(input logic [W-1:0] a_rn, input logic [W-1:0] a_op2,
                        input logic a_c, input logic a_rev,
                        input logic [W-1:0] e_y, input logic [3:0] e_f,
                        input int ign_at, input int rst_at);
    int lat;
    int busy_cnt;
    int done_cnt;
    logic got;
    logic hold_bad;
    logic [W-1:0] y_prev;
    y_prev = y;
    rn = a_rn; op2 = a_op2; carry = a_c; rev = a_rev;
    start = 1'b1;
    if (rst_at == 0) exp_q.push_back({e_y, e_f});
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble inputs: the DUT must work from its latched copies.
    rn = $urandom; op2 = $urandom; carry = 1'($urandom_range(0, 1)); rev = 1'($urandom_range(0, 1));
    lat = 0; busy_cnt = 0; got = 1'b0; hold_bad = 1'b0;
    while (!got && lat < 100) begin
      if (done) begin
        got = 1'b1;
        chk("latency", 64'(lat), 64'(W));
        chk("busy_cycles", 64'(busy_cnt), 64'(W));
        chk("busy_low_in_done", 64'(busy), 64'd0);
        chk("y_hold_in_run", 64'(hold_bad), 64'd0);
      end else begin
        if (busy) busy_cnt++;
        if (y !== y_prev) hold_bad = 1'b1;
        start = (ign_at != 0 && busy_cnt == ign_at);
        if (start) begin
          rn = 32'h0000_0100; op2 = 32'h0000_0001; carry = 1'b1; rev = 1'b0;
        end
        if (rst_at != 0 && busy_cnt == rst_at) begin
          rst_n = 1'b0;
          @(posedge clk); #1;
          rst_n = 1'b1;
          chk("rst_mid_busy", 64'(busy), 64'd0);
          chk("rst_mid_y", 64'(y), 64'd0);
          chk("rst_mid_cnzv", 64'(cnzv), 64'd0);
          done_cnt = 0;
          repeat (40) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
          end
          chk("rst_mid_no_done", 64'(done_cnt), 64'd0);
          return;
        end
        @(posedge clk); #1;
        lat++;
      end
    end
    start = 1'b0;
    if (!got) chk("done_timeout", 64'd1, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b0; start = 1'b0; rn = '0; op2 = '0; carry = 1'b0; rev = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_y", 64'(y), 64'd0);
    chk("reset_cnzv", 64'(cnzv), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Start from IDLE, then back-to-back starts accepted in each DONE cycle.
    run_op(32'd5,          32'd3,          1'b1, 1'b0, 32'h0000_0002, 4'b1000, 0, 0); // SUB
    run_op(32'd3,          32'd5,          1'b1, 1'b0, 32'hFFFF_FFFE, 4'b0100, 0, 0); // borrow
    run_op(32'd7,          32'd7,          1'b1, 1'b0, 32'h0000_0000, 4'b1010, 0, 0); // zero
    run_op(32'h8000_0000,  32'd1,          1'b1, 1'b0, 32'h7FFF_FFFF, 4'b1001, 0, 0); // overflow
    run_op(32'd5,          32'd3,          1'b0, 1'b0, 32'h0000_0001, 4'b1000, 0, 0); // SBC
    run_op(32'd3,          32'd5,          1'b1, 1'b1, 32'h0000_0002, 4'b1000, 0, 0); // RSB
    run_op(32'd5,          32'd3,          1'b0, 1'b1, 32'hFFFF_FFFD, 4'b0100, 0, 0); // RSC
    run_op(32'd0,          32'd0,          1'b0, 1'b0, 32'hFFFF_FFFF, 4'b0100, 0, 0); // SBC 0-0-1
    run_op(32'h7FFF_FFFF,  32'hFFFF_FFFF,  1'b1, 1'b0, 32'h8000_0000, 4'b0101, 0, 0); // +ovf

    // Stray start at busy cycle 10 must be ignored.
    run_op(32'h1234_5678,  32'h0000_0678,  1'b1, 1'b0, 32'h1234_5000, 4'b1000, 10, 0);

    // Idle gap, then reset in the middle of an operation.
    repeat (3) @(posedge clk);
    #1;
    run_op(32'd9,          32'd4,          1'b1, 1'b0, 32'd5,         4'b1000, 0, 15);

    // Fresh operation after reset.
    run_op(32'd100,        32'd58,         1'b1, 1'b0, 32'd42,        4'b1000, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Multi-cycle, bit-serial subtractor for the CPU datapath; the inverse counterpart of the combinational adder.
- Computes ARM-style SUB/SBC/RSB/RSC as A + ~B + carry_in, one bit per clock, LSB first.
- Produces the result word and CNZV flags with ARM carry semantics (C = NOT borrow).
- Sits beside the ALU. Driven by the execute stage through a start/busy/done handshake.

Parameters:
- WIDTH, 32 (`WordWidth): operand/result width in bits. Minimum 2.
- CNT_W, 6: bit-counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- in_Clk  input  1  clock; all state updates on rising edge.
- in_Rst_N  input  1  synchronous, active-low reset.
- in_Start  input  1  request; sampled only while not busy.
- in_Rn  input  WIDTH  first operand.
- in_Op2  input  WIDTH  second operand.
- in_Carry  input  1  carry in: 1 for SUB/RSB; the C flag for SBC/RSC.
- in_Reverse  input  1  0: Rn - Op2; 1: Op2 - Rn (RSB/RSC).
- out_Busy  output  1  high while bits are being processed.
- out_Done  output  1  one-cycle pulse when the result is valid.
- out_Y  output  WIDTH  difference; held until the next accepted start.
- out_CNZV  output  4  {C,N,Z,V}; held alongside out_Y.

Behaviour:
- Reset (in_Rst_N=0 at an edge):
  - State becomes IDLE.
  - out_Busy=0, out_Done=0, out_Y=0, out_CNZV=0, counter=0.
  - Applies mid-operation too: any in-flight result is discarded and no Done is issued.
- States:
  - IDLE: Busy=0.
  - RUN: Busy=1.
  - DONE: Busy=0, Done=1 for exactly one cycle, then IDLE.
- IDLE/DONE + in_Start=1 at an edge:
  - Latch A = Reverse ? Op2 : Rn.
  - Latch B = Reverse ? Rn : Op2.
  - Latch carry = in_Carry.
  - Clear counter; enter RUN.
  - A start in the DONE cycle is accepted, so back-to-back operations are supported.
- in_Start while in RUN is ignored. Latched operands are unaffected by later input changes.
- RUN, per edge:
  - {c, y[i]} = A[i] + ~B[i] + c, with i = counter.
  - Counter increments.
  - On the edge that processes i = WIDTH-1, go to DONE and update out_Y/out_CNZV.
- Latency:
  - Start sampled at edge k.
  - Busy is high for cycles k+1..k+WIDTH.
  - Done is high in the cycle following edge k+WIDTH (32 cycles for the default WIDTH).
- out_Y/out_CNZV change only on the edge that enters DONE. They are stable otherwise, including throughout RUN.
- Flags:
  - C = final carry out (1 = no borrow).
  - N = Y[WIDTH-1].
  - Z = (Y == 0).
  - V = (A[MSB] != B[MSB]) && (Y[MSB] != A[MSB]).
- Wrap-around is modulo 2^WIDTH. No saturation.

Test Plan:
- Rn=5, Op2=3, Carry=1, Rev=0 -> Y=0x00000002, CNZV=4'b1000; Done exactly 32 cycles after the start edge; Busy high for 32 cycles.
- Rn=3, Op2=5, Carry=1 -> Y=0xFFFFFFFE, CNZV=4'b0100. Rn=7, Op2=7 -> Y=0, CNZV=4'b1010.
- Rn=0x80000000, Op2=1, Carry=1 -> Y=0x7FFFFFFF, CNZV=4'b1001 (signed overflow).
- SBC: Rn=5, Op2=3, Carry=0 -> Y=1, CNZV=4'b1000. RSB: Rn=3, Op2=5, Rev=1, Carry=1 -> Y=2, CNZV=4'b1000.
- Pulse Start again at busy cycle 10 with different operands -> ignored; first result delivered unchanged. Start asserted during the Done cycle -> accepted; second Done follows 32 cycles later.
- Deassert in_Rst_N at busy cycle 15 -> next cycle Busy=0, Y=0, CNZV=0, no Done pulse; a fresh start afterwards completes correctly.
